rx_engine: RTL and testbench
============================

# rx_engine

Receive engine for the UART processor; the downstream stage of the transmit engine. It accepts the serial line driven by a transmit engine at the same baud setting, synchronizes it, and detects the start bit. It samples each bit at mid-bit-time, reassembles the character, checks parity and stop bit, and presents the byte with ready and error flags to the processor read port.

## Interface
Parameters:
- none (baud and framing are run-time inputs, shared with the transmit engine)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- RX  input  1  serial line, idle high, asynchronous to clk
- max  input  19  bit-time terminal count; one bit time = max+1 clocks; max >= 3
- EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits
- PEN  input  1  parity enable
- OHEL  input  1  parity sense: 0 = even, 1 = odd
- READS  input  1  one-clock read strobe from processor; clears the ready and error flags
- UART_DATA  output  8  received character; bit 7 forced 0 in 7-bit mode
- RXRDY  output  1  character available, active high
- PERR  output  1  parity error on the held character
- FERR  output  1  framing error (stop bit sampled 0)
- OVF  output  1  overrun: a new character completed while RXRDY was still set

## Operation
- Input synchronizer: two flops on RX, both reset to 1. All logic uses the second flop (rxs).
- Frame length N = 9 + EIGHT + PEN bits: start, D0..D6, [D7 if EIGHT], [parity if PEN], stop. This matches the transmit engine's bit order.
- Bit-time counter bt (19 bits) runs only in START and DATA and clears on every state entry. The sample strobe fires when:
  - START: bt == (max >> 1)
  - DATA: bt == max
- bt clears on each strobe. Bit counter bc (4 bits) counts samples taken in DATA.
- State machine:
  - IDLE: wait for rxs == 0, then go to START.
  - START: at the half-bit strobe, if rxs == 0 go to DATA with bc = 0; otherwise it is a false start and the FSM returns to IDLE.
  - DATA: on each strobe, shift rxs into a 10-bit shift register (right shift, MSB in) and increment bc. When bc reaches N-1 (stop bit taken), go to DONE.
  - DONE: one cycle. Extract fields, update the output flags, then return to IDLE.
- Field extraction in DONE:
  - Data is right-justified to the data width. UART_DATA = {EIGHT ? D7 : 0, D6..D0}.
  - Parity check when PEN = 1: the computed value is XOR(data bits, incl. D7 when EIGHT) ^ OHEL; PERR_new = received parity != computed value. PERR_new = 0 when PEN = 0.
  - FERR_new = ~stop.
- Updates in DONE:
  - UART_DATA, PERR, FERR are loaded.
  - RXRDY is set.
  - OVF is set if RXRDY == 1 and READS == 0 in that cycle; otherwise OVF holds.
- READS clears RXRDY, PERR, FERR and OVF.
- READS and DONE in the same cycle: DONE's updates win, and OVF is not set.
- Framing and baud inputs are sampled live. Changing them mid-frame is undefined; the bench must not do it.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE; bt = 0; bc = 0; synchronizer = 11
  - UART_DATA = 0x00; RXRDY = 0; PERR = 0; FERR = 0; OVF = 0
- Reset mid-frame aborts the frame with no flag update.
- Start detection latency: 2 clocks of synchronizer plus 1 clock to enter START.
- First data sample occurs (max>>1)+1 + (max+1) clocks after START entry, i.e. at mid-bit.
- RXRDY rises 1 clock after the stop-bit sample (DONE cycle) and is visible the following cycle together with data and flags.
- A new start bit is accepted the cycle after DONE, so back-to-back frames with one stop bit are received.
- bt never exceeds max; bc never exceeds 11.

## Test plan
- Reset: hold rst = 0 with RX toggling -> all outputs 0, FSM stays IDLE; release -> no RXRDY without a valid start bit.
- 8N1, max = 15, send 0xA5 -> UART_DATA = 0xA5, RXRDY = 1, PERR = FERR = OVF = 0; READS pulse -> RXRDY = 0.
- 7-bit even parity (EIGHT=0, PEN=1, OHEL=0): send 0x35 with a correct parity bit -> UART_DATA = 0x35, PERR = 0. Resend with the parity bit inverted -> PERR = 1.
- 8 odd parity: send 0xFF with the stop bit forced 0 -> FERR = 1, UART_DATA = 0xFF.
- False start: RX low for max>>2 clocks, then high -> no RXRDY, FSM back in IDLE. A following valid 0x3C is received correctly.
- Overrun and reset mid-frame:
  - Send 0x11 then 0x22 with no READS -> UART_DATA = 0x22, OVF = 1. READS then clears all flags.
  - Repeat with READS coinciding with the 0x22 DONE cycle -> OVF = 0.
  - Assert rst mid-frame -> outputs 0; the next frame is received correctly.

Source files
------------

// File: rtl/rx_engine.sv
// UART receive engine: synchronizes the serial line, samples each bit at mid-bit
// and presents the reassembled character with ready/parity/framing/overrun flags.
module rx_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic [18:0] max,
  input  logic        EIGHT,
  input  logic        PEN,
  input  logic        OHEL,
  input  logic        READS,
  output logic [7:0]  UART_DATA,
  output logic        RXRDY,
  output logic        PERR,
  output logic        FERR,
  output logic        OVF
);

  localparam int unsigned BT_W = 19;
  localparam int unsigned BC_W = 4;
  localparam int unsigned SR_W = 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic            rx_meta_q, rxs_q;
  logic [1:0]      state_q, state_d;
  logic [BT_W-1:0] bt_q, bt_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [7:0]      data_q, data_d;
  logic            rxrdy_q, rxrdy_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            ovf_q, ovf_d;

  logic            strobe_c;
  logic [BC_W-1:0] samples_c;
  logic [BC_W-1:0] bc_inc_c;
  logic [1:0]      shift_c;
  logic [7:0]      data_raw_c;
  logic [7:0]      data_c;
  logic            perr_new_c;

  // Samples taken after the start bit: data bits, optional parity, stop.
  assign samples_c = 4'd8 + {3'd0, EIGHT} + {3'd0, PEN};
  assign bc_inc_c  = bc_q + 4'd1;
  assign strobe_c  = (state_q == S_START) ? (bt_q == (max >> 1)) : (bt_q == max);

  // Stop lands in sr[9], parity in sr[8]; shorter frames leave D0 higher up.
  assign shift_c    = 2'd2 - {1'b0, EIGHT} - {1'b0, PEN};
  assign data_raw_c = 8'(sr_q >> shift_c);
  assign data_c     = {EIGHT & data_raw_c[7], data_raw_c[6:0]};
  assign perr_new_c = PEN & (sr_q[8] ^ (^data_c) ^ OHEL);

  always_comb begin
    state_d = state_q;
    bt_d    = bt_q;
    bc_d    = bc_q;
    sr_d    = sr_q;
    data_d  = data_q;
    rxrdy_d = rxrdy_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;

    if (READS) begin
      rxrdy_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        bt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (strobe_c) begin
          bt_d = '0;
          if (!rxs_q) begin
            state_d = S_DATA;
            bc_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bt_d = bt_q + 19'd1;
        end
      end
      S_DATA: begin
        if (strobe_c) begin
          bt_d = '0;
          sr_d = {rxs_q, sr_q[SR_W-1:1]};
          bc_d = bc_inc_c;
          if (bc_inc_c == samples_c) state_d = S_DONE;
        end else begin
          bt_d = bt_q + 19'd1;
        end
      end
      default: begin
        // DONE: loads override a coincident read; overrun only if unread.
        state_d = S_IDLE;
        bt_d    = '0;
        data_d  = data_c;
        perr_d  = perr_new_c;
        ferr_d  = ~sr_q[9];
        rxrdy_d = 1'b1;
        if (rxrdy_q && !READS) ovf_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      bt_q      <= '0;
      bc_q      <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      rxrdy_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      bt_q      <= bt_d;
      bc_q      <= bc_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      rxrdy_q   <= rxrdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign UART_DATA = data_q;
  assign RXRDY     = rxrdy_q;
  assign PERR      = perr_q;
  assign FERR      = ferr_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_rx_engine.sv
// Bench for rx_engine: serial frames built from the framing rules, checked against
// a flag-level model of what the processor read port should show.
module tb_rx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_r;
  logic [18:0] max_r;
  logic        eight_r, pen_r, ohel_r, reads_r;
  logic [7:0]  uart_data;
  logic        rxrdy, perr, ferr, ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_data;
  logic       m_rdy, m_perr, m_ferr, m_ovf;

  rx_engine dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (rx_r),
    .max       (max_r),
    .EIGHT     (eight_r),
    .PEN       (pen_r),
    .OHEL      (ohel_r),
    .READS     (reads_r),
    .UART_DATA (uart_data),
    .RXRDY     (rxrdy),
    .PERR      (perr),
    .FERR      (ferr),
    .OVF       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, 32'(uart_data), 32'(m_data));
    chk({tag, ".rdy"},  32'(rxrdy),     32'(m_rdy));
    chk({tag, ".perr"}, 32'(perr),      32'(m_perr));
    chk({tag, ".ferr"}, 32'(ferr),      32'(m_ferr));
    chk({tag, ".ovf"},  32'(ovf),       32'(m_ovf));
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_r = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    reads_r = 1'b1;
    @(posedge clk);
    #1;
    reads_r = 1'b0;
    m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  // Transmit one frame like the transmit engine; optionally pulse READS in the
  // cycle the receiver completes the character (mid-bit of stop + 4 clocks).
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                            input bit rd_at_done, input int tail);
    logic [11:0] bits;
    logic [7:0]  dm;
    int          m, h, w, nb, idx, done_c;
    m  = int'(max_r) + 1;
    h  = int'(max_r >> 1);
    w  = eight_r ? 8 : 7;
    nb = 9 + int'(eight_r) + int'(pen_r);
    dm = eight_r ? d : {1'b0, d[6:0]};
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < w; i++) bits[1+i] = d[i];
    idx = 1 + w;
    if (pen_r) begin
      bits[idx] = (^dm) ^ ohel_r ^ bad_par;
      idx++;
    end
    bits[idx] = ~bad_stop;
    done_c = (nb - 1) * m + 4 + h;
    for (int c = 0; c < nb * m + tail; c++) begin
      rx_r    = (c < nb * m) ? bits[c / m] : 1'b1;
      reads_r = rd_at_done && (c == done_c);
      @(posedge clk);
      #1;
    end
    reads_r = 1'b0;
    if (rd_at_done) m_ovf = 1'b0;
    else if (m_rdy) m_ovf = 1'b1;
    m_rdy  = 1'b1;
    m_data = dm;
    m_perr = pen_r & bad_par;
    m_ferr = bad_stop;
  endtask

  initial begin
    logic [7:0] d;
    logic       bp;
    int         m;

    rst = 1'b0; rx_r = 1'b1; reads_r = 1'b0;
    max_r = 19'd15; eight_r = 1'b1; pen_r = 1'b0; ohel_r = 1'b0;
    model_reset();

    // Reset held with the line toggling.
    for (int i = 0; i < 12; i++) begin
      rx_r = i[0];
      @(posedge clk);
      #1;
    end
    chk_all("reset");
    rx_r = 1'b1;
    rst  = 1'b1;
    idle(60);
    chk_all("post_reset_idle");

    // 8N1 0xA5, then read.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8);
    chk_all("8n1_a5");
    do_read();
    chk_all("8n1_a5_read");

    // 7-bit even parity, good then inverted parity.
    eight_r = 1'b0; pen_r = 1'b1; ohel_r = 1'b0;
    send_frame(8'h35, 1'b0, 1'b0, 1'b0, 8);
    chk_all("7e1_35");
    do_read();
    send_frame(8'h35, 1'b1, 1'b0, 1'b0, 8);
    chk_all("7e1_35_badpar");
    do_read();

    // 8 odd parity with the stop bit forced low.
    eight_r = 1'b1; pen_r = 1'b1; ohel_r = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 8);
    idle(64);
    chk_all("8o1_ff_ferr");
    do_read();
    chk_all("8o1_read");

    // False start, then a valid 0x3C.
    eight_r = 1'b1; pen_r = 1'b0;
    rx_r = 1'b0;
    repeat (int'(max_r >> 2)) @(posedge clk);
    #1;
    idle(64);
    chk_all("false_start");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8);
    chk_all("after_false_3c");
    do_read();

    // Overrun: back-to-back with no read.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 8);
    chk_all("ovf_22");
    do_read();
    chk_all("ovf_read");

    // Read coinciding with completion of the second frame.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 8);
    chk_all("read_at_done");

    // Reset in the middle of a frame.
    m = int'(max_r) + 1;
    rx_r = 1'b0; repeat (m) @(posedge clk);
    rx_r = 1'b1; repeat (m) @(posedge clk);
    rx_r = 1'b0; repeat (m / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all("midframe_reset");
    idle(4);
    rst = 1'b1;
    idle(3 * m);
    chk_all("midframe_reset_idle");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8);
    chk_all("after_reset_5a");
    do_read();

    // Random framing, baud, data, parity errors and read skipping.
    for (int t = 0; t < 30; t++) begin
      max_r   = 19'($urandom_range(3, 40));
      eight_r = 1'($urandom_range(0, 1));
      pen_r   = 1'($urandom_range(0, 1));
      ohel_r  = 1'($urandom_range(0, 1));
      d       = 8'($urandom_range(0, 255));
      bp      = pen_r && ($urandom_range(0, 3) == 0);
      send_frame(d, bp, 1'b0, 1'b0, 8);
      chk_all($sformatf("rand%0d", t));
      if ($urandom_range(0, 3) != 0) begin
        do_read();
        chk_all($sformatf("rand%0d_read", t));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
